// File: rtl/sid.sv
// Shared SID data types: 24-bit signed samples and the filter's three state voltages.
package sid;
    typedef logic signed [23:0] s24_t;

    typedef struct packed {
        s24_t vhp;
        s24_t vbp;
        s24_t vlp;
    } filter_v_t;
endpackage

// File: rtl/sid_filter_seq_if.sv
// Stage/state link between the pass sequencer (master) and the shared filter datapath (slave).
interface sid_filter_seq_if;
    logic [2:0]     stage_o;
    logic [1:0]     sid_sel_o;
    sid::filter_v_t state_o;
    sid::filter_v_t state_i;
    sid::s24_t      audio_i;

    modport master (
        output stage_o,
        output sid_sel_o,
        output state_o,
        input  state_i,
        input  audio_i
    );

    modport slave (
        input  stage_o,
        input  sid_sel_o,
        input  state_o,
        output state_i,
        output audio_i
    );
endinterface

// File: rtl/sid_filter_seq.sv
// Pass sequencer for the time-multiplexed SID filter: walks each instance through
// stages 1..7, captures its state and audio on a stage-0 cycle, then reports all results.
module sid_filter_seq #(
    parameter int N_SIDS = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [N_SIDS-1:0] clr_i,
    sid_filter_seq_if.master  fif,
    output sid::s24_t         audio_o [N_SIDS],
    output logic              audio_valid_o,
    output logic              busy_o,
    output logic              overrun_o
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        CAPTURE = 2'd2
    } seq_state_t;

    localparam logic [1:0] LAST_SEL = 2'(N_SIDS - 1);

    seq_state_t     state_r;
    seq_state_t     state_s;
    logic [2:0]     stage_r;
    logic [2:0]     stage_s;
    logic [1:0]     sel_r;
    logic [1:0]     sel_s;
    logic           valid_r;
    logic           valid_s;
    logic           overrun_r;
    logic           busy_s;
    logic           capture_s;
    sid::filter_v_t mem_r   [N_SIDS];
    sid::s24_t      audio_r [N_SIDS];
    sid::filter_v_t state_mux_s;

    assign busy_s = (state_r != IDLE);

    // Next-state and stage/select sequencing.
    always_comb begin
        state_s   = state_r;
        stage_s   = stage_r;
        sel_s     = sel_r;
        valid_s   = 1'b0;
        capture_s = 1'b0;
        case (state_r)
            IDLE: begin
                sel_s = 2'd0;
                if (start_i) begin
                    state_s = RUN;
                    stage_s = 3'd1;
                end else begin
                    stage_s = 3'd0;
                end
            end
            RUN: begin
                if (stage_r == 3'd7) begin
                    state_s = CAPTURE;
                    stage_s = 3'd0;
                end else begin
                    stage_s = stage_r + 3'd1;
                end
            end
            CAPTURE: begin
                capture_s = 1'b1;
                if (sel_r == LAST_SEL) begin
                    state_s = IDLE;
                    stage_s = 3'd0;
                    sel_s   = 2'd0;
                    valid_s = 1'b1;
                end else begin
                    state_s = RUN;
                    stage_s = 3'd1;
                    sel_s   = sel_r + 2'd1;
                end
            end
            default: begin
                state_s = IDLE;
                stage_s = 3'd0;
                sel_s   = 2'd0;
            end
        endcase
    end

    // Sequencer registers; a start seen mid-pass is dropped but remembered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            stage_r   <= 3'd0;
            sel_r     <= 2'd0;
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            stage_r   <= stage_s;
            sel_r     <= sel_s;
            valid_r   <= valid_s;
            overrun_r <= overrun_r | (start_i & busy_s);
        end
    end

    // Per-instance state and audio storage; clear wins over a same-edge capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_SIDS; k++) begin
                mem_r[k]   <= '0;
                audio_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_SIDS; k++) begin
                if (clr_i[k]) begin
                    mem_r[k] <= '0;
                end else if (capture_s && (sel_r == 2'(k))) begin
                    mem_r[k] <= fif.state_i;
                end
                if (capture_s && (sel_r == 2'(k))) begin
                    audio_r[k] <= fif.audio_i;
                end
            end
        end
    end

    // State fed back to the filter for the instance currently selected.
    always_comb begin
        state_mux_s = '0;
        for (int k = 0; k < N_SIDS; k++) begin
            if (sel_r == 2'(k)) begin
                state_mux_s = mem_r[k];
            end else begin
                state_mux_s = state_mux_s;
            end
        end
    end

    assign fif.stage_o   = stage_r;
    assign fif.sid_sel_o = sel_r;
    assign fif.state_o   = state_mux_s;
    assign audio_o       = audio_r;
    assign audio_valid_o = valid_r;
    assign busy_o        = busy_s;
    assign overrun_o     = overrun_r;
endmodule
